// File: rtl/write_back_register_file_pkg.sv
// Shared CPU pipeline definitions: write-back control bit positions and
// default datapath widths used by the pipe registers and register file.
package write_back_register_file_pkg;

  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;
  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  // Unpack the raw MEM/WB control field into named flags.
  function automatic wb_ctrl_t decode_wb_ctrl(input logic [1:0] ctrl);
    wb_ctrl_t c;
    c.reg_write  = ctrl[WB_REGWRITE_BIT];
    c.mem_to_reg = ctrl[WB_MEMTOREG_BIT];
    return c;
  endfunction

endpackage

// File: rtl/write_back_register_file_if.sv
// MEM/WB write-back and decode-stage read bundle for the register file.
interface write_back_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [1:0]        wb_control;
  logic [DATA_W-1:0] wb_read_data;
  logic [DATA_W-1:0] wb_alu_result;
  logic [ADDR_W-1:0] wb_write_reg;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [31:0]       retire_count;

  modport master (
    output wb_control, wb_read_data, wb_alu_result, wb_write_reg, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wb_data, wb_we, retire_count
  );

  modport slave (
    input  wb_control, wb_read_data, wb_alu_result, wb_write_reg, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wb_data, wb_we, retire_count
  );
endinterface

// File: rtl/write_back_register_file_wb_select.sv
// Write-back value mux (load result vs ALU result) and effective write enable.
module wb_select
  import write_back_register_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [1:0]        i_wb_control,
  input  logic [DATA_W-1:0] i_read_data,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [ADDR_W-1:0] i_write_reg,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_wb_we
);

  wb_ctrl_t w_ctrl;
  assign w_ctrl = decode_wb_ctrl(i_wb_control);

  // Select the write-back value; the load path only wins when MemtoReg is set.
  always_comb begin
    o_wb_data = {DATA_W{1'b0}};
    if (w_ctrl.mem_to_reg) begin
      o_wb_data = i_read_data;
    end else begin
      o_wb_data = i_alu_result;
    end
  end

  // Writes to x0 never commit, so they are masked here rather than in storage.
  assign o_wb_we = w_ctrl.reg_write && (i_write_reg != {ADDR_W{1'b0}});

endmodule

// File: rtl/write_back_register_file.sv
// Write-back stage register file: flop storage for x1..xN, write-through
// bypass to both decode read ports, and a retired-write counter.
module write_back_register_file
  import write_back_register_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                     clk,
  input logic                     reset,
  write_back_register_file_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [1:DEPTH-1];
  logic [31:0]       r_retire_count;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_we;
  logic [DATA_W-1:0] w_rd_data_a;
  logic [DATA_W-1:0] w_rd_data_b;
  wb_ctrl_t          w_ctrl;

  assign w_ctrl = decode_wb_ctrl(bus.wb_control);

  wb_select #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wb_select (
    .i_wb_control (bus.wb_control),
    .i_read_data  (bus.wb_read_data),
    .i_alu_result (bus.wb_alu_result),
    .i_write_reg  (bus.wb_write_reg),
    .o_wb_data    (w_wb_data),
    .o_wb_we      (w_wb_we)
  );

  // Storage update: reset clears every entry and overrides a same-cycle write.
  always_ff @(posedge clk) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (reset) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end else if (w_wb_we && (bus.wb_write_reg == ADDR_W'(i))) begin
        r_regs[i] <= w_wb_data;
      end else begin
        r_regs[i] <= r_regs[i];
      end
    end
  end

  // Retire counter counts RegWrite cycles, x0 included, wrapping silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire_count <= 32'd0;
    end else if (w_ctrl.reg_write) begin
      r_retire_count <= r_retire_count + 32'd1;
    end else begin
      r_retire_count <= r_retire_count;
    end
  end

  // Read ports: index 0 matches no stored entry and falls through to zero.
  always_comb begin
    w_rd_data_a = {DATA_W{1'b0}};
    w_rd_data_b = {DATA_W{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      w_rd_data_a = w_rd_data_a | ((bus.rd_addr_a == ADDR_W'(i)) ? r_regs[i] : {DATA_W{1'b0}});
      w_rd_data_b = w_rd_data_b | ((bus.rd_addr_b == ADDR_W'(i)) ? r_regs[i] : {DATA_W{1'b0}});
    end
  end

  // Bypass lets decode see the value being written this cycle.
  assign bus.rd_data_a    = (w_wb_we && (bus.rd_addr_a == bus.wb_write_reg)) ? w_wb_data : w_rd_data_a;
  assign bus.rd_data_b    = (w_wb_we && (bus.rd_addr_b == bus.wb_write_reg)) ? w_wb_data : w_rd_data_b;
  assign bus.wb_data      = w_wb_data;
  assign bus.wb_we        = w_wb_we;
  assign bus.retire_count = r_retire_count;

endmodule

// File: doc/write_back_register_file.md
WRITE_BACK_REGISTER_FILE -- requirements
Module: write_back_register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width; depth is 2**ADDR_W (32).
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port wb_control, input, 2, write-back control from the MEM/WB stage: bit1 = RegWrite, bit0 = MemtoReg.
REQ-006 Port wb_read_data, input, DATA_W, data-memory load result.
REQ-007 Port wb_alu_result, input, DATA_W, ALU result.
REQ-008 Port wb_write_reg, input, ADDR_W, destination register index.
REQ-009 Port rd_addr_a / rd_addr_b, input, ADDR_W each, decode-stage read indices.
REQ-010 Port rd_data_a / rd_data_b, output, DATA_W each, read data.
REQ-011 Port wb_data, output, DATA_W, selected write-back value (combinational, for forwarding).
REQ-012 Port wb_we, output, 1, effective write enable (RegWrite and wb_write_reg != 0).
REQ-013 Port retire_count, output, 32, count of cycles with RegWrite=1.

Function
REQ-014 wb_data SHALL equal wb_read_data when MemtoReg=1, else wb_alu_result.
REQ-015 On each rising clk with reset=0 and wb_we=1, entry[wb_write_reg] SHALL be loaded with wb_data; no other entry changes.
REQ-016 Writes to index 0 SHALL be discarded; entry 0 SHALL always read as 0.
REQ-017 Reads SHALL be combinational, zero-cycle latency from rd_addr_x to rd_data_x.
REQ-018 Write-through bypass: when wb_we=1 and rd_addr_x == wb_write_reg, rd_data_x SHALL equal wb_data in the same cycle (covers write-first ordering for the decode stage).
REQ-019 Ports A and B SHALL be independent; same address on both returns identical data, including during a bypassed write.
REQ-020 retire_count SHALL increment by 1 on each clk with reset=0 and RegWrite=1, including RegWrite to index 0.
REQ-021 retire_count SHALL wrap from 0xFFFFFFFF to 0 without flag.
REQ-022 RegWrite=0 SHALL leave all entries and retire_count unchanged regardless of MemtoReg and data inputs.
REQ-023 X or unknown data on wb_read_data SHALL NOT reach any entry when MemtoReg=0.

Reset
REQ-024 While reset=1 at a rising clk, all entries SHALL clear to 0 and retire_count SHALL clear to 0; any concurrent write is dropped.
REQ-025 Reset asserted mid-stream SHALL take priority over a write in the same cycle; first write after deassertion takes effect on the next clk.
REQ-026 Combinational outputs (wb_data, wb_we, rd_data bypass) SHALL follow inputs during reset; rd_data from storage reads 0 after the reset edge.

Structure
REQ-027 Control bit positions (WB_REGWRITE_BIT=1, WB_MEMTOREG_BIT=0), DATA_W and ADDR_W defaults SHALL live in the shared cpu package used by the pipe registers.
REQ-028 The write-back mux SHALL be a sub-module wb_select (MemtoReg mux plus wb_we generation); storage, bypass and counter stay in the top.
REQ-029 Storage SHALL be a flip-flop array of 2**ADDR_W - 1 entries (index 0 not stored).

Verification
REQ-030 Reset then read all 32 indices on both ports -> all 0, retire_count=0.
REQ-031 wb_control=2'b10, alu=0x0000_1234, reg=5; next cycle rd_addr_a=5 -> 0x0000_1234; with control=2'b11, read_data=0xDEAD_BEEF, reg=5 -> 0xDEAD_BEEF; retire_count=2.
REQ-032 Same-cycle bypass: write reg=7 data 0xA5A5_A5A5 with rd_addr_a=rd_addr_b=7 -> both ports 0xA5A5_A5A5 before the clk edge.
REQ-033 Write to reg 0 with 0xFFFF_FFFF -> rd_data 0 before and after edge, wb_we=0, retire_count incremented by 1.
REQ-034 Write reg 9=0x1111_1111, then assert reset while presenting write reg 9=0x2222_2222 -> reg 9 reads 0, retire_count=0.
REQ-035 RegWrite=0 for 10 cycles with random data/addresses -> no entry changes, retire_count unchanged; force counter to 0xFFFF_FFFF then one write -> 0.
